// File: rtl/lcd_cmd_seq_if.sv
// Bus bundle between the CPU-side request port, the sequencer and lcd_ctrl.
// The slave modport is the sequencer's view; the master modport is the
// environment's view (upstream requester plus downstream lcd_ctrl).
interface lcd_cmd_seq_if;
    logic       i_req_vld;
    logic       o_req_rdy;
    logic       i_req_rs;
    logic [7:0] i_req_data;
    logic       o_init_done;
    logic       o_vld;
    logic       i_rdy;
    logic [7:0] o_LCD_DATA;
    logic       o_LCD_RS;
    logic       o_LCD_RW;
    logic       o_LCD_ON;

    modport slave (
        input  i_req_vld,
        input  i_req_rs,
        input  i_req_data,
        input  i_rdy,
        output o_req_rdy,
        output o_init_done,
        output o_vld,
        output o_LCD_DATA,
        output o_LCD_RS,
        output o_LCD_RW,
        output o_LCD_ON
    );

    modport master (
        output i_req_vld,
        output i_req_rs,
        output i_req_data,
        output i_rdy,
        input  o_req_rdy,
        input  o_init_done,
        input  o_vld,
        input  o_LCD_DATA,
        input  o_LCD_RS,
        input  o_LCD_RW,
        input  o_LCD_ON
    );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Command sequencer in front of lcd_ctrl. Waits out the LCD power-up time,
// plays a fixed four-command init sequence, then forwards CPU requests one
// at a time, spacing every write by the LCD execution time of the command
// just issued (the busy flag is never read, so RW is tied low).
module lcd_cmd_seq #(
    parameter int         T_PERIOD_NS = 20,
    parameter int         T_PWRUP_NS  = 40000000,
    parameter int         T_CMD_NS    = 40000,
    parameter int         T_CLR_NS    = 1600000,
    parameter logic [7:0] INIT_FN     = 8'h38,
    parameter logic [7:0] INIT_DISP   = 8'h0C,
    parameter logic [7:0] INIT_CLR    = 8'h01,
    parameter logic [7:0] INIT_ENTRY  = 8'h06
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    lcd_cmd_seq_if.slave bus
);

    // Delays in clock cycles; a zero result would make a wait vanish, so clamp to 1
    localparam int C_PWRUP_RAW = T_PWRUP_NS / T_PERIOD_NS;
    localparam int C_CMD_RAW   = T_CMD_NS / T_PERIOD_NS;
    localparam int C_CLR_RAW   = T_CLR_NS / T_PERIOD_NS;
    localparam int C_PWRUP     = (C_PWRUP_RAW < 1) ? 1 : C_PWRUP_RAW;
    localparam int C_CMD       = (C_CMD_RAW < 1) ? 1 : C_CMD_RAW;
    localparam int C_CLR       = (C_CLR_RAW < 1) ? 1 : C_CLR_RAW;
    localparam int C_MAX_A     = (C_PWRUP > C_CMD) ? C_PWRUP : C_CMD;
    localparam int C_MAX       = (C_MAX_A > C_CLR) ? C_MAX_A : C_CLR;
    localparam int CNT_W       = $clog2(C_MAX + 1);

    // Counter terminal values: the counter restarts at 0, so a wait of N
    // cycles ends on the edge where the counter already holds N-1
    localparam logic [CNT_W-1:0] L_PWRUP_END = CNT_W'(C_PWRUP - 1);
    localparam logic [CNT_W-1:0] L_CMD_END   = CNT_W'(C_CMD - 1);
    localparam logic [CNT_W-1:0] L_CLR_END   = CNT_W'(C_CLR - 1);

    typedef enum logic [1:0] {
        S_PWRUP,
        S_ISSUE,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_vld;
    logic             r_reqRdy;
    logic             r_initDone;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_on;
    logic             w_slowCmd;
    logic             w_waitEnd;

    // Init sequence ROM, indexed by position in the sequence
    function automatic logic [7:0] initByte(input logic [1:0] idx);
        case (idx)
            2'd0:    initByte = INIT_FN;
            2'd1:    initByte = INIT_DISP;
            2'd2:    initByte = INIT_CLR;
            default: initByte = INIT_ENTRY;
        endcase
    endfunction

    // Clear and return-home need the long execution delay; everything else the short one
    always_comb begin
        w_slowCmd = 1'b0;
        w_waitEnd = 1'b0;
        if (!r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03)) begin
            w_slowCmd = 1'b1;
        end
        w_waitEnd = (r_cnt == (w_slowCmd ? L_CLR_END : L_CMD_END));
    end

    // Sequencer FSM; every output comes straight from a register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_PWRUP;
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_vld      <= 1'b0;
            r_reqRdy   <= 1'b0;
            r_initDone <= 1'b0;
            r_data     <= 8'h00;
            r_rs       <= 1'b0;
            r_on       <= 1'b0;
        end else begin
            case (r_state)
                S_PWRUP: begin
                    if (r_cnt == L_PWRUP_END) begin
                        r_cnt   <= '0;
                        r_on    <= 1'b1;
                        r_data  <= INIT_FN;
                        r_rs    <= 1'b0;
                        r_vld   <= 1'b1;
                        r_idx   <= 2'd0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_vld && bus.i_rdy) begin
                        r_vld   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_waitEnd) begin
                        r_cnt <= '0;
                        if (!r_initDone && r_idx != 2'd3) begin
                            r_idx   <= r_idx + 2'd1;
                            r_data  <= initByte(r_idx + 2'd1);
                            r_rs    <= 1'b0;
                            r_vld   <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_initDone <= 1'b1;
                            r_reqRdy   <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.i_req_vld && r_reqRdy) begin
                        r_data   <= bus.i_req_data;
                        r_rs     <= bus.i_req_rs;
                        r_reqRdy <= 1'b0;
                        r_vld    <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                default: begin
                    r_state <= S_PWRUP;
                end
            endcase
        end
    end

    assign bus.o_vld       = r_vld;
    assign bus.o_req_rdy   = r_reqRdy;
    assign bus.o_init_done = r_initDone;
    assign bus.o_LCD_DATA  = r_data;
    assign bus.o_LCD_RS    = r_rs;
    assign bus.o_LCD_RW    = 1'b0;
    assign bus.o_LCD_ON    = r_on;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq with short timing: power-up 10 cycles, ordinary
// command 5 cycles, clear/home 20 cycles. Expected bytes go into a queue
// when stimulus is driven and are popped at each downstream handshake.
module tb_lcd_cmd_seq;

    logic clk;
    logic rstN;
    int   cyc;
    int   nTests;
    int   nFail;

    typedef struct {
        logic [7:0] data;
        logic       rs;
    } exp_t;

    exp_t expQ[$];

    lcd_cmd_seq_if bus();

    lcd_cmd_seq #(
        .T_PERIOD_NS(20),
        .T_PWRUP_NS (200),
        .T_CMD_NS   (100),
        .T_CLR_NS   (400)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .bus    (bus)
    );

    // 20 ns clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Rising-edge count, read at falling edges as the cycle index
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from a handshake to the next vld/rdy rise: execution delay + 1
    function automatic int expGap(input logic [7:0] d, input logic rs);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return 21;
        return 6;
    endfunction

    // Advance at least one falling edge, stop at the first handshake
    task automatic waitHandshake(output bit ok, output logic [7:0] d,
                                 output logic rs, output int at);
        ok = 1'b0; d = '0; rs = 1'b0; at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_vld === 1'b1 && bus.i_rdy === 1'b1) begin
                ok = 1'b1; d = bus.o_LCD_DATA; rs = bus.o_LCD_RS; at = cyc;
                return;
            end
        end
    endtask

    // Advance at least one falling edge, stop when the request port is ready
    task automatic waitReqRdy(output bit ok, output int at);
        ok = 1'b0; at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_req_rdy === 1'b1) begin
                ok = 1'b1; at = cyc;
                return;
            end
        end
    endtask

    // Pop the scoreboard and compare against an observed handshake
    task automatic scoreHandshake(input string name, input bit ok,
                                  input logic [7:0] d, input logic rs);
        exp_t e;
        nTests++;
        if (!ok) begin
            nFail++;
            $display("[TB] FAIL %s: no handshake within bound", name);
            return;
        end
        if (expQ.size() == 0) begin
            nFail++;
            $display("[TB] FAIL %s: unexpected handshake data=%0h", name, d);
            return;
        end
        e = expQ.pop_front();
        if ({rs, d} !== {e.rs, e.data}) begin
            nFail++;
            $display("[TB] FAIL %s: got rs=%0b data=%0h expected rs=%0b data=%0h",
                     name, rs, d, e.rs, e.data);
        end
    endtask

    // Drive a request at a falling edge while the port is ready
    task automatic sendReq(input logic rs, input logic [7:0] d);
        exp_t e;
        bus.i_req_vld  = 1'b1;
        bus.i_req_rs   = rs;
        bus.i_req_data = d;
        e.data = d; e.rs = rs;
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        nTests++;
        if ({bus.o_vld, bus.o_req_rdy, bus.o_init_done} !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000",
                     {bus.o_vld, bus.o_req_rdy, bus.o_init_done});
        end
        nTests++;
        if ({bus.o_LCD_DATA, bus.o_LCD_RS, bus.o_LCD_RW, bus.o_LCD_ON} !== 11'h000) begin
            nFail++;
            $display("[TB] FAIL reset_lcd: got %h expected 000",
                     {bus.o_LCD_DATA, bus.o_LCD_RS, bus.o_LCD_RW, bus.o_LCD_ON});
        end
    endtask

    task automatic test_init();
        bit         ok;
        logic [7:0] d;
        logic       rs;
        int         at;
        int         relCyc;
        int         prevAt;
        int         gap;
        logic [7:0] initSeq [4];
        exp_t       e;
        initSeq[0] = 8'h38; initSeq[1] = 8'h0C; initSeq[2] = 8'h01; initSeq[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            e.data = initSeq[i]; e.rs = 1'b0;
            expQ.push_back(e);
        end
        rstN   = 1'b1;
        relCyc = cyc;
        prevAt = 0;
        gap    = 0;
        for (int i = 0; i < 4; i++) begin
            waitHandshake(ok, d, rs, at);
            scoreHandshake("init_byte", ok, d, rs);
            nTests++;
            if (i == 0) begin
                if (at - relCyc !== 10 || bus.o_LCD_ON !== 1'b1) begin
                    nFail++;
                    $display("[TB] FAIL powerup: got delay=%0d on=%b expected delay=10 on=1",
                             at - relCyc, bus.o_LCD_ON);
                end
            end else if (at - prevAt !== gap) begin
                nFail++;
                $display("[TB] FAIL init_gap%0d: got %0d expected %0d", i, at - prevAt, gap);
            end
            prevAt = at;
            gap    = expGap(initSeq[i], 1'b0);
        end
        waitReqRdy(ok, at);
        nTests++;
        if (!ok || at - prevAt !== 6 || bus.o_init_done !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL init_done: got delay=%0d done=%b expected delay=6 done=1",
                     at - prevAt, bus.o_init_done);
        end
    endtask

    task automatic test_single_data();
        bit         ok;
        logic [7:0] d;
        logic       rs;
        int         at;
        int         acc;
        int         hs;
        sendReq(1'b1, 8'h41);
        acc = cyc;
        waitHandshake(ok, d, rs, at);
        bus.i_req_vld = 1'b0;
        hs = at;
        scoreHandshake("data_byte", ok, d, rs);
        nTests++;
        if (hs - acc !== 1 || bus.o_req_rdy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL data_latency: got %0d rdy=%b expected 1 rdy=0",
                     hs - acc, bus.o_req_rdy);
        end
        waitReqRdy(ok, at);
        nTests++;
        if (!ok || at - hs !== 6) begin
            nFail++;
            $display("[TB] FAIL data_gap: got %0d expected 6", at - hs);
        end
    endtask

    task automatic test_cmd_delays();
        bit         ok;
        logic [7:0] d;
        logic       rs;
        int         at;
        int         hs;
        logic [7:0] cmds [3];
        cmds[0] = 8'h01; cmds[1] = 8'h02; cmds[2] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            sendReq(1'b0, cmds[i]);
            waitHandshake(ok, d, rs, at);
            bus.i_req_vld = 1'b0;
            hs = at;
            scoreHandshake("cmd_byte", ok, d, rs);
            for (int k = 0; k < 3; k++) @(negedge clk);
            nTests++;
            if (bus.o_LCD_DATA !== cmds[i] || bus.o_vld !== 1'b0 || bus.o_LCD_RW !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL wait_hold: got data=%0h vld=%b rw=%b expected data=%0h vld=0 rw=0",
                         bus.o_LCD_DATA, bus.o_vld, bus.o_LCD_RW, cmds[i]);
            end
            waitReqRdy(ok, at);
            nTests++;
            if (!ok || at - hs !== expGap(cmds[i], 1'b0)) begin
                nFail++;
                $display("[TB] FAIL cmd_gap %0h: got %0d expected %0d",
                         cmds[i], at - hs, expGap(cmds[i], 1'b0));
            end
        end
    endtask

    task automatic test_backpressure();
        bit         ok;
        int         at;
        int         hs;
        bit         bad;
        exp_t       e;
        bus.i_rdy = 1'b0;
        sendReq(1'b1, 8'h55);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_vld !== 1'b1 || bus.o_LCD_DATA !== 8'h55 ||
                bus.o_LCD_RS !== 1'b1 || bus.o_req_rdy !== 1'b0) bad = 1'b1;
        end
        nTests++;
        if (bad) begin
            nFail++;
            $display("[TB] FAIL stall_hold: got vld=%b data=%0h rdy=%b expected vld=1 data=55 rdy=0",
                     bus.o_vld, bus.o_LCD_DATA, bus.o_req_rdy);
        end
        bus.i_req_vld = 1'b0;
        bus.i_rdy     = 1'b1;
        hs = cyc;
        scoreHandshake("stall_byte", bus.o_vld === 1'b1, bus.o_LCD_DATA, bus.o_LCD_RS);
        waitReqRdy(ok, at);
        nTests++;
        if (!ok || at - hs !== 6 || bus.o_vld !== 1'b0 || bus.o_LCD_DATA !== 8'h55) begin
            nFail++;
            $display("[TB] FAIL stall_release: got gap=%0d vld=%b data=%0h expected gap=6 vld=0 data=55",
                     at - hs, bus.o_vld, bus.o_LCD_DATA);
        end
        nTests++;
        if (expQ.size() !== 0) begin
            nFail++;
            $display("[TB] FAIL stall_extra: got %0d pending expected 0", expQ.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        bit         ok;
        logic [7:0] d;
        logic       rs;
        int         at;
        int         relCyc;
        exp_t       e;
        sendReq(1'b0, 8'h01);
        waitHandshake(ok, d, rs, at);
        bus.i_req_vld = 1'b0;
        scoreHandshake("pre_reset", ok, d, rs);
        repeat (3) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        nTests++;
        if ({bus.o_vld, bus.o_req_rdy, bus.o_init_done, bus.o_LCD_DATA,
             bus.o_LCD_RS, bus.o_LCD_RW, bus.o_LCD_ON} !== 14'h0) begin
            nFail++;
            $display("[TB] FAIL midreset: got %h expected 0",
                     {bus.o_vld, bus.o_req_rdy, bus.o_init_done, bus.o_LCD_DATA,
                      bus.o_LCD_RS, bus.o_LCD_RW, bus.o_LCD_ON});
        end
        rstN   = 1'b1;
        relCyc = cyc;
        expQ.delete();
        e.data = 8'h38; e.rs = 1'b0;
        expQ.push_back(e);
        waitHandshake(ok, d, rs, at);
        scoreHandshake("restart_byte", ok, d, rs);
        nTests++;
        if (at - relCyc !== 10) begin
            nFail++;
            $display("[TB] FAIL restart_delay: got %0d expected 10", at - relCyc);
        end
    endtask

    initial begin
        cyc            = 0;
        nTests         = 0;
        nFail          = 0;
        rstN           = 1'b0;
        bus.i_req_vld  = 1'b0;
        bus.i_req_rs   = 1'b0;
        bus.i_req_data = 8'h00;
        bus.i_rdy      = 1'b1;
        test_reset();
        test_init();
        test_single_data();
        test_cmd_delays();
        test_backpressure();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
